// File: rtl/data_mem_responder.sv
// data_mem_responder: zero-wait-state data memory slave for a simple core.
// Decodes a word-addressed RAM, a console transmit FIFO with sticky
// overflow, and a status/control register pair. Reads are combinational;
// all state updates happen on the rising clock edge.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   addr, data_out    byte address and write data from the core
//   mem_en, mem_read  access strobe and direction (1 = read)
//   data_in           combinational read data back to the core
//   cons_valid/data   console FIFO head (valid/data)
//   cons_ready        downstream accepts the head when cons_valid=1
module data_mem_responder #(
  parameter int RAM_WORDS    = 256,
  parameter int CONSOLE_ADDR = 1024,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] data_out,
  input  logic        mem_en,
  input  logic        mem_read,
  output logic [31:0] data_in,
  output logic        cons_valid,
  output logic [31:0] cons_data,
  input  logic        cons_ready
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
  localparam logic [31:0] TX_ADDR   = 32'(CONSOLE_ADDR);
  localparam logic [31:0] ST_ADDR   = TX_ADDR + 32'd4;
  localparam logic [31:0] CT_ADDR   = TX_ADDR + 32'd8;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [31:0] ram  [RAM_WORDS];
  logic [31:0] fifo [FIFO_DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          overflow;

  // decode
  logic          ram_hit, tx_hit, st_hit, ct_hit;
  logic          rd_req, wr_req;
  logic [AW-1:0] widx;

  assign ram_hit = addr < RAM_BYTES;
  assign tx_hit  = addr == TX_ADDR;
  assign st_hit  = addr == ST_ADDR;
  assign ct_hit  = addr == CT_ADDR;
  assign rd_req  = mem_en & mem_read;
  assign wr_req  = mem_en & ~mem_read;
  assign widx    = addr[AW+1:2];

  // FIFO handshake. A pop frees the slot the same cycle, so a push into a
  // full FIFO is accepted when a pop accompanies it.
  logic full, pop, push_req, push, ovf_evt, ovf_clr;

  assign full     = count == FULL_CNT;
  assign pop      = cons_valid & cons_ready;
  assign push_req = wr_req & tx_hit;
  assign push     = push_req & (~full | pop);
  assign ovf_evt  = push_req & full & ~pop;
  assign ovf_clr  = wr_req & ct_hit & data_out[0];

  assign cons_valid = count != '0;
  // head storage is not reset, so mask it while empty
  assign cons_data  = cons_valid ? fifo[rd_ptr] : 32'd0;

  logic [31:0] status_word;
  always_comb begin
    status_word        = '0;
    status_word[8]     = overflow;
    status_word[PW:0]  = count;
  end

  always_comb begin
    data_in = '0;
    if (rd_req) begin
      if (ram_hit)     data_in = ram[widx];
      else if (st_hit) data_in = status_word;
    end
  end

  // storage arrays: no reset
  always_ff @(posedge clk) begin
    if (wr_req && ram_hit) ram[widx] <= data_out;
    if (push && rst_n)     fifo[wr_ptr] <= data_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      // set beats clear when both land in one cycle
      if (ovf_evt)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with immediate-assertion checks.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, data_out, data_in, cons_data;
  logic        mem_en, mem_read, cons_valid, cons_ready;

  int checks = 0;
  int failures = 0;

  data_mem_responder #(.RAM_WORDS(256), .CONSOLE_ADDR(1024), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .data_out(data_out),
    .mem_en(mem_en), .mem_read(mem_read), .data_in(data_in),
    .cons_valid(cons_valid), .cons_data(cons_data), .cons_ready(cons_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mem_en = 1'b1; mem_read = 1'b0; addr = a; data_out = d;
    tick();
    mem_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    mem_en = 1'b1; mem_read = 1'b1; addr = a;
    #1;
    chk(tag, data_in, exp);
    tick();
    mem_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; mem_en = 1'b0; mem_read = 1'b0; addr = '0; data_out = '0;
    cons_ready = 1'b0;
    #2;
    chk("rst_valid", {31'd0, cons_valid}, 32'd0);
    chk("rst_data", cons_data, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    rd_chk("rst_status", 32'd1028, 32'd0);

    // RAM write/read, low address bits ignored
    wr(32'h10, 32'hDEADBEEF);
    rd_chk("ram_rd_10", 32'h10, 32'hDEADBEEF);
    rd_chk("ram_rd_13", 32'h13, 32'hDEADBEEF);
    mem_en = 1'b0; mem_read = 1'b1; addr = 32'h10; #1;
    chk("rd_no_en", data_in, 32'd0);
    mem_en = 1'b1; mem_read = 1'b0; #1;
    chk("rd_on_write", data_in, 32'd0);
    mem_en = 1'b0;
    tick();
    wr(32'd1020, 32'hA5A5_0001);
    rd_chk("ram_top_word", 32'd1020, 32'hA5A5_0001);
    rd_chk("tx_read_zero", 32'd1024, 32'd0);

    // overflow: five pushes into a depth-4 FIFO
    for (int i = 1; i <= 5; i++) wr(32'd1024, 32'(i));
    rd_chk("ovf_status", 32'd1028, 32'h104);
    cons_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", cons_data, 32'(i));
      tick();
    end
    chk("drain_empty", {31'd0, cons_valid}, 32'd0);
    cons_ready = 1'b0;
    rd_chk("ovf_sticky", 32'd1028, 32'h100);
    wr(32'd1028, 32'hFFFF_FFFF);
    rd_chk("status_wr_ign", 32'd1028, 32'h100);
    wr(32'd1032, 32'd1);
    rd_chk("ovf_clear", 32'd1028, 32'h0);

    // push+pop while full
    for (int i = 10; i <= 13; i++) wr(32'd1024, 32'(i));
    cons_ready = 1'b1;
    wr(32'd1024, 32'd9);
    cons_ready = 1'b0;
    rd_chk("full_pushpop", 32'd1028, 32'h004);
    cons_ready = 1'b1;
    chk("fp_d0", cons_data, 32'd11); tick();
    chk("fp_d1", cons_data, 32'd12); tick();
    chk("fp_d2", cons_data, 32'd13); tick();
    chk("fp_d3", cons_data, 32'd9);  tick();
    chk("fp_empty", {31'd0, cons_valid}, 32'd0);

    // push into empty with ready high
    wr(32'd1024, 32'd7);
    chk("empty_push_v", {31'd0, cons_valid}, 32'd1);
    chk("empty_push_d", cons_data, 32'd7);
    tick();
    chk("empty_popped", {31'd0, cons_valid}, 32'd0);
    cons_ready = 1'b0;

    // unmapped address
    wr(32'd2000, 32'h1234_5678);
    rd_chk("unmapped_rd", 32'd2000, 32'd0);
    rd_chk("ram_intact", 32'h10, 32'hDEADBEEF);
    rd_chk("status_after", 32'd1028, 32'h0);

    // mid-operation reset
    wr(32'd1024, 32'd21);
    wr(32'd1024, 32'd22);
    wr(32'd1024, 32'd23);
    chk("pre_rst_valid", {31'd0, cons_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_v", {31'd0, cons_valid}, 32'd0);
    chk("async_rst_d", cons_data, 32'd0);
    tick();
    rst_n = 1'b1;
    rd_chk("rst_status2", 32'd1028, 32'h0);
    rd_chk("rst_ram_keep", 32'h10, 32'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
